// File: rtl/sdf_twiddle_mul.sv
// Twiddle-multiply stage of a radix-2^2 SDF FFT: frame counter, table addressing,
// complex rotation with rounding/saturation, and bypass for the trivial twiddle.
module sdf_twiddle_mul #(
  parameter int WIDTH = 16,
  parameter int LOG_N = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic [LOG_N-1:0] tw_addr,
  input  logic [WIDTH-1:0] tw_re,
  input  logic [WIDTH-1:0] tw_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_last
);

  localparam logic signed [2*WIDTH:0]  RND     = (2*WIDTH+1)'(2**(WIDTH-2));
  localparam logic signed [WIDTH+1:0]  SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0]  SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  logic [LOG_N-1:0] cnt;
  logic [1:0]       k;
  logic [LOG_N-3:0] n;

  // Quadrant index is bit-reversed so the row order matches the radix-2^2 decomposition.
  assign k       = {cnt[LOG_N-2], cnt[LOG_N-1]};
  assign n       = cnt[LOG_N-3:0];
  assign tw_addr = {2'b00, n} * {{(LOG_N-2){1'b0}}, k};

  logic                      s1_v, s1_byp, s1_last;
  logic signed [WIDTH-1:0]   s1_re, s1_im;
  logic                      s2_v, s2_byp, s2_last;
  logic        [WIDTH-1:0]   s2_re, s2_im;
  logic signed [2*WIDTH-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
  logic                      s3_v, s3_byp, s3_last;
  logic        [WIDTH-1:0]   s3_re, s3_im;
  logic signed [2*WIDTH:0]   s3_sr, s3_si;

  logic signed [2*WIDTH:0] sr_rnd, si_rnd;
  logic                    unused_lsb;

  assign sr_rnd     = s3_sr + RND;
  assign si_rnd     = s3_si + RND;
  assign unused_lsb = ^{sr_rnd[WIDTH-2:0], si_rnd[WIDTH-2:0]};

  function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
    if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      s1_v    <= 1'b0;
      s1_byp  <= 1'b0;
      s1_last <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s2_v    <= 1'b0;
      s2_byp  <= 1'b0;
      s2_last <= 1'b0;
      s2_re   <= '0;
      s2_im   <= '0;
      s2_rr   <= '0;
      s2_ii   <= '0;
      s2_ri   <= '0;
      s2_ir   <= '0;
      s3_v    <= 1'b0;
      s3_byp  <= 1'b0;
      s3_last <= 1'b0;
      s3_re   <= '0;
      s3_im   <= '0;
      s3_sr   <= '0;
      s3_si   <= '0;
      do_en   <= 1'b0;
      do_last <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
    end else begin
      if (di_en) cnt <= cnt + 1'b1;
      // Stage 1: capture sample; the table registers tw for tw_addr on this same edge.
      s1_v    <= di_en;
      s1_byp  <= (tw_addr == '0);
      s1_last <= (cnt == {LOG_N{1'b1}});
      s1_re   <= $signed(di_re);
      s1_im   <= $signed(di_im);
      // Stage 2: twiddle now aligned with the stage-1 sample.
      s2_v    <= s1_v;
      s2_byp  <= s1_byp;
      s2_last <= s1_last;
      s2_re   <= s1_re;
      s2_im   <= s1_im;
      s2_rr   <= s1_re * $signed(tw_re);
      s2_ii   <= s1_im * $signed(tw_im);
      s2_ri   <= s1_re * $signed(tw_im);
      s2_ir   <= s1_im * $signed(tw_re);
      // Stage 3: complex sums at full precision.
      s3_v    <= s2_v;
      s3_byp  <= s2_byp;
      s3_last <= s2_last;
      s3_re   <= s2_re;
      s3_im   <= s2_im;
      s3_sr   <= {s2_rr[2*WIDTH-1], s2_rr} - {s2_ii[2*WIDTH-1], s2_ii};
      s3_si   <= {s2_ri[2*WIDTH-1], s2_ri} + {s2_ir[2*WIDTH-1], s2_ir};
      // Output: round, saturate or bypass; data holds while invalid.
      do_en   <= s3_v;
      do_last <= s3_v & s3_last;
      if (s3_v) begin
        do_re <= s3_byp ? s3_re : sat(sr_rnd[2*WIDTH:WIDTH-1]);
        do_im <= s3_byp ? s3_im : sat(si_rnd[2*WIDTH:WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_sdf_twiddle_mul.sv
// Self-checking bench for sdf_twiddle_mul: registered twiddle table model, directed
// vectors, reset/gap sequences and randomized traffic against a queue-based model.
module tb_sdf_twiddle_mul;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        di_en = 1'b0;
  logic [15:0] di_re = '0;
  logic [15:0] di_im = '0;
  logic [5:0]  tw_addr;
  logic [15:0] tw_re, tw_im;
  logic        do_en;
  logic [15:0] do_re, do_im;
  logic        do_last;

  sdf_twiddle_mul #(.WIDTH(16), .LOG_N(6)) dut (
    .clock   (clock),
    .reset   (reset),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .tw_addr (tw_addr),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im),
    .do_last (do_last)
  );

  always #5 clock = ~clock;

  logic [15:0] tab_re [64];
  logic [15:0] tab_im [64];

  // One-cycle registered twiddle ROM.
  always @(posedge clock) begin
    tw_re <= tab_re[tw_addr];
    tw_im <= tab_im[tw_addr];
  end

  typedef struct {
    int          due;
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } exp_t;

  typedef struct {
    string       name;
    int          cnt;
    logic [15:0] wre, wim, dre, dim, ere, eim;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[3];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mcnt = 0;
  logic [15:0] held_re = '0;
  logic [15:0] held_im = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int addr_of(input int c);
    int k;
    k = ((c >> 4) & 1) * 2 + ((c >> 5) & 1);
    return (c & 15) * k;
  endfunction

  function automatic logic [15:0] sat_round(input longint s);
    longint r;
    r = (s + 16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic check_out();
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("do_en", do_en, 1);
      chk("do_re", do_re, q[0].re);
      chk("do_im", do_im, q[0].im);
      chk("do_last", do_last, q[0].last);
      held_re = q[0].re;
      held_im = q[0].im;
      void'(q.pop_front());
    end else begin
      chk("do_en_idle", do_en, 0);
      chk("do_last_idle", do_last, 0);
      chk("hold_re", do_re, held_re);
      chk("hold_im", do_im, held_im);
    end
  endtask

  task automatic tick(input logic en, input logic [15:0] re, input logic [15:0] im);
    exp_t   e;
    int     a;
    longint xr, xi, wr, wi;
    di_en = en;
    di_re = re;
    di_im = im;
    chk("tw_addr", tw_addr, addr_of(mcnt));
    if (en && !reset) begin
      a = addr_of(mcnt);
      if (a == 0) begin
        e.re = re;
        e.im = im;
      end else begin
        xr = $signed(re);
        xi = $signed(im);
        wr = $signed(tab_re[a]);
        wi = $signed(tab_im[a]);
        e.re = sat_round(xr * wr - xi * wi);
        e.im = sat_round(xr * wi + xi * wr);
      end
      e.last = (mcnt == 63);
      e.due  = cyc + 4;
      q.push_back(e);
      mcnt = (mcnt + 1) % 64;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_out();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_do_en", do_en, 0);
    chk("rst_do_re", do_re, 0);
    chk("rst_do_im", do_im, 0);
    chk("rst_tw_addr", tw_addr, 0);
    q.delete();
    mcnt    = 0;
    held_re = '0;
    held_im = '0;
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"bypass", 0,  16'h7777, 16'h3333, 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC};
    vecs[1] = '{"mult",   40, 16'h5A82, 16'hA57E, 16'h4000, 16'h0000, 16'h2D41, 16'hD2BF};
    vecs[2] = '{"satrnd", 17, 16'h5A82, 16'h5A82, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF};
    for (int i = 0; i < 64; i++) begin
      tab_re[i] = 16'($urandom);
      tab_im[i] = 16'($urandom);
    end

    do_reset();

    // Full frame back-to-back plus wrap into the next frame.
    for (int i = 0; i < 66; i++) tick(1'b1, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 4; i++) tick(1'b0, '0, '0);

    // Directed vectors at chosen frame positions.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      tab_re[addr_of(vecs[v].cnt)] = vecs[v].wre;
      tab_im[addr_of(vecs[v].cnt)] = vecs[v].wim;
      while (mcnt < vecs[v].cnt) tick(1'b1, 16'($urandom), 16'($urandom));
      tick(1'b1, vecs[v].dre, vecs[v].dim);
      for (int i = 0; i < 3; i++) tick(1'b0, '0, '0);
      chk({vecs[v].name, "_re"}, do_re, vecs[v].ere);
      chk({vecs[v].name, "_im"}, do_im, vecs[v].eim);
    end

    // Reset mid-stream aborts in-flight samples; next sample restarts at address 0.
    for (int i = 0; i < 22; i++) tick(1'b1, 16'($urandom), 16'($urandom));
    do_reset();
    tick(1'b1, 16'h0BAD, 16'hC0DE);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, '0);
    chk("post_rst_re", do_re, 16'h0BAD);
    chk("post_rst_im", do_im, 16'hC0DE);

    // Gap pattern inside a quadrant with a nonzero twiddle step.
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 16'($urandom), 16'($urandom));
    begin
      logic [6:0] pat;
      pat = 7'b1011001;
      for (int i = 6; i >= 0; i--) tick(pat[i], 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 4; i++) tick(1'b0, '0, '0);
    chk("gap_addr", tw_addr, 16);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      if (i == 150 || i == 310) do_reset();
      tick(($urandom % 4) != 0, 16'($urandom), 16'($urandom));
    end

    for (int i = 0; i < 5; i++) tick(1'b0, '0, '0);
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
